// File: rtl/noc_result_receiver_pkg.sv
// Shared types for the NoC result receiver: flit encoding, header field
// positions and the receive FSM state enum.
package noc_pkg;

    typedef enum logic [1:0] {
        FLIT_ILLEGAL = 2'b00,
        FLIT_HEAD    = 2'b01,
        FLIT_BODY    = 2'b10,
        FLIT_TAIL    = 2'b11
    } flit_type_t;

    localparam int FLIT_TYPE_LSB = 32;
    localparam int HDR_DEST_LSB  = 24;
    localparam int HDR_SRC_LSB   = 16;
    localparam int HDR_LEN_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_DROP  = 2'd2,
        ST_DRAIN = 2'd3
    } rx_state_t;

endpackage

// File: rtl/noc_result_receiver_if.sv
// Flit ingress and payload egress bundle of the result receiver.
// Both channels transfer a beat on a cycle where valid && ready; a sender
// keeps valid and its data stable until that cycle, ready may be anything.
interface noc_result_receiver_if #(
    parameter int FLIT_W = 34
);
    logic              flit_in_valid;
    logic              flit_in_ready;
    logic [FLIT_W-1:0] flit_in_data;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic [7:0]        out_src;
    logic              out_last;

    modport master (
        output flit_in_valid, flit_in_data, out_ready,
        input  flit_in_ready, out_valid, out_data, out_src, out_last
    );

    modport slave (
        input  flit_in_valid, flit_in_data, out_ready,
        output flit_in_ready, out_valid, out_data, out_src, out_last
    );
endinterface

// File: rtl/noc_result_receiver_buffer.sv
// Payload store for one packet: flop array, synchronous write, combinational read.
module result_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);
    logic [31:0] mem_q [DEPTH];

    // Contents are don't-care after reset, so the array has no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/noc_result_receiver.sv
// NoC ejection endpoint: buffers packets addressed to NODE_ID and replays them
// as a word stream. Optional tail checksum check under RESULT_CHECKSUM_EN.
module noc_result_receiver
    import noc_pkg::*;
#(
    parameter int         FLIT_W        = 34,
    parameter logic [7:0] NODE_ID       = 8'd0,
    parameter int         MAX_WORDS     = 16,
    parameter int         EXPECTED_PKTS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    noc_result_receiver_if.slave  rx,
    output logic [15:0]           pkt_count,
    output logic                  data_received,
    output logic                  err_proto,
    output logic                  err_len,
`ifdef RESULT_CHECKSUM_EN
    output logic                  err_csum,
`endif
    output rx_state_t             dbg_state
);
    localparam int AW = $clog2(MAX_WORDS);
    localparam int CW = AW + 2;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);
    localparam logic [CW-1:0] SAT_CNT = CW'(MAX_WORDS + 1);

    rx_state_t   state_q, state_d;
    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic [AW-1:0] rd_idx_q, rd_idx_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  src_q, src_d;
    logic [15:0] pkt_count_q, pkt_count_d;
    logic        data_received_q, data_received_d;
    logic        err_proto_q, err_proto_d;
    logic        err_len_q, err_len_d;
`ifdef RESULT_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;
    logic        err_csum_q, err_csum_d;
`endif

    flit_type_t    flit_type;
    logic [31:0]   payload;
    logic          accept;
    logic          buf_we;
    logic [31:0]   rd_data;
    logic [CW-1:0] stored;
    logic [CW-1:0] last_idx;
    logic          last_word;
    logic          deliver;

    assign flit_type = flit_type_t'(rx.flit_in_data[FLIT_TYPE_LSB +: 2]);
    assign payload   = rx.flit_in_data[31:0];

    assign rx.flit_in_ready = (state_q != ST_DRAIN);
    assign accept           = rx.flit_in_valid && rx.flit_in_ready;

    // Overflowed packets replay only what fit in the buffer.
    assign stored    = (wr_cnt_q > MAX_CNT) ? MAX_CNT : wr_cnt_q;
    assign last_idx  = stored - CW'(1);
    assign last_word = (state_q == ST_DRAIN) && (CW'(rd_idx_q) == last_idx);

    assign rx.out_valid = (state_q == ST_DRAIN);
    assign rx.out_last  = last_word;
    assign rx.out_data  = rx.out_valid ? rd_data : 32'd0;
    assign rx.out_src   = rx.out_valid ? src_q : 8'd0;

    result_buffer #(
        .DEPTH (MAX_WORDS)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (wr_cnt_q[AW-1:0]),
        .wdata (payload),
        .raddr (rd_idx_q),
        .rdata (rd_data)
    );

    always_comb begin
        state_d         = state_q;
        wr_cnt_d        = wr_cnt_q;
        rd_idx_d        = rd_idx_q;
        len_d           = len_q;
        src_d           = src_q;
        pkt_count_d     = pkt_count_q;
        data_received_d = data_received_q;
        err_proto_d     = err_proto_q;
        err_len_d       = err_len_q;
        buf_we          = 1'b0;
        deliver         = 1'b0;
`ifdef RESULT_CHECKSUM_EN
        csum_d          = csum_q;
        err_csum_d      = err_csum_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (accept && flit_type != FLIT_HEAD) begin
                    err_proto_d = 1'b1;
                end
            end
            ST_RECV: begin
                if (accept) begin
                    case (flit_type)
                        FLIT_BODY: begin
                            buf_we = (wr_cnt_q < MAX_CNT);
                            if (wr_cnt_q != SAT_CNT) begin
                                wr_cnt_d = wr_cnt_q + CW'(1);
                            end
`ifdef RESULT_CHECKSUM_EN
                            csum_d = csum_q + payload[15:0];
`endif
                        end
                        FLIT_TAIL: begin
                            if (16'(wr_cnt_q) != len_q || wr_cnt_q > MAX_CNT) begin
                                err_len_d = 1'b1;
                            end
`ifdef RESULT_CHECKSUM_EN
                            if (payload[15:0] != csum_q) begin
                                err_csum_d = 1'b1;
                            end
`endif
                            if (wr_cnt_q != '0) begin
                                state_d  = ST_DRAIN;
                                rd_idx_d = '0;
                            end else begin
                                state_d = ST_IDLE;
                                deliver = 1'b1;
                            end
                        end
                        default: err_proto_d = 1'b1;
                    endcase
                end
            end
            ST_DROP: begin
                if (accept && flit_type == FLIT_TAIL) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (rx.out_ready) begin
                    if (last_word) begin
                        state_d = ST_IDLE;
                        deliver = 1'b1;
                    end else begin
                        rd_idx_d = rd_idx_q + AW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A HEAD in RECV abandons the current packet and restarts like IDLE.
        if (accept && flit_type == FLIT_HEAD &&
            (state_q == ST_IDLE || state_q == ST_RECV)) begin
            if (payload[HDR_DEST_LSB +: 8] == NODE_ID) begin
                state_d  = ST_RECV;
                src_d    = payload[HDR_SRC_LSB +: 8];
                len_d    = payload[HDR_LEN_LSB +: 16];
                wr_cnt_d = '0;
`ifdef RESULT_CHECKSUM_EN
                csum_d   = 16'd0;
`endif
            end else begin
                state_d = ST_DROP;
            end
        end

        if (deliver) begin
            if (pkt_count_q != 16'hFFFF) begin
                pkt_count_d = pkt_count_q + 16'd1;
            end
            data_received_d = data_received_q || (int'(pkt_count_d) >= EXPECTED_PKTS);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            wr_cnt_q        <= '0;
            rd_idx_q        <= '0;
            len_q           <= '0;
            src_q           <= '0;
            pkt_count_q     <= '0;
            data_received_q <= 1'b0;
            err_proto_q     <= 1'b0;
            err_len_q       <= 1'b0;
`ifdef RESULT_CHECKSUM_EN
            csum_q          <= '0;
            err_csum_q      <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            wr_cnt_q        <= wr_cnt_d;
            rd_idx_q        <= rd_idx_d;
            len_q           <= len_d;
            src_q           <= src_d;
            pkt_count_q     <= pkt_count_d;
            data_received_q <= data_received_d;
            err_proto_q     <= err_proto_d;
            err_len_q       <= err_len_d;
`ifdef RESULT_CHECKSUM_EN
            csum_q          <= csum_d;
            err_csum_q      <= err_csum_d;
`endif
        end
    end

    assign pkt_count     = pkt_count_q;
    assign data_received = data_received_q;
    assign err_proto     = err_proto_q;
    assign err_len       = err_len_q;
`ifdef RESULT_CHECKSUM_EN
    assign err_csum      = err_csum_q;
`endif
    assign dbg_state     = state_q;
endmodule
